// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants, encodings and width helpers for the sram-like arbiter slice.
// The fixed-priority variant is selected with SRAM_ARB_FIXED_PRIO_EN.
package sram_like_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_MAX_OUTSTANDING = 4;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Packed request bundle layout: {wr, size, wstrb, addr, wdata}
  function automatic int reqBundleW(input int addrW, input int dataW);
    return 1 + 2 + (dataW / 8) + addrW + dataW;
  endfunction

  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the upstream channel ports and the downstream sram-like port.
// slave = arbiter view, master = the view of whoever drives channels and memory.
interface sram_like_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_wr;
  logic [2*NUM_CH-1:0]          ch_size;
  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb;
  logic [ADDR_W*NUM_CH-1:0]     ch_addr;
  logic [DATA_W*NUM_CH-1:0]     ch_wdata;
  logic [NUM_CH-1:0]            ch_addr_ok;
  logic [NUM_CH-1:0]            ch_data_ok;
  logic [DATA_W-1:0]            ch_rdata;

  logic                         mem_req;
  logic                         mem_wr;
  logic [1:0]                   mem_size;
  logic [DATA_W/8-1:0]          mem_wstrb;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_addr_ok;
  logic                         mem_data_ok;
  logic [DATA_W-1:0]            mem_rdata;

  modport slave (
    input  ch_req, ch_wr, ch_size, ch_wstrb, ch_addr, ch_wdata,
    output ch_addr_ok, ch_data_ok, ch_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output ch_req, ch_wr, ch_size, ch_wstrb, ch_addr, ch_wdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_like_arbiter_arb_id_fifo.sv
// In-order FIFO of channel IDs for accepted-but-unanswered requests.
// Push is ignored when full and pop when empty, so the count can never wrap.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A single-entry FIFO keeps its pointers pinned at zero
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (DEPTH == 1) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter onto one downstream port with in-order response routing.
// Default round-robin; define SRAM_ARB_FIXED_PRIO_EN for lowest-index fixed priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  bus
);

  localparam int CH_W   = chWidth(NUM_CH);
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = reqBundleW(ADDR_W, DATA_W);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  logic [REQ_W-1:0]  w_bundle [NUM_CH];
  logic [CH_W-1:0]   w_pick;
  logic [CH_W-1:0]   w_idx;
  logic              w_found;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_memReq;
  logic              w_hs;
  logic              w_pop;
  logic [NUM_CH-1:0] w_addrOk;
  logic [NUM_CH-1:0] w_dataOk;
  arb_state_e        r_state;
  logic [CH_W-1:0]   r_lockCh;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign w_bundle[c] = {bus.ch_wr[c],
                          bus.ch_size[2*c +: 2],
                          bus.ch_wstrb[STRB_W*c +: STRB_W],
                          bus.ch_addr[ADDR_W*c +: ADDR_W],
                          bus.ch_wdata[DATA_W*c +: DATA_W]};
  end

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'(i);
      if (!w_found && bus.ch_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end
`else
  logic [CH_W-1:0] r_ptr;

  // Search starts at the channel after the last one accepted
  always_comb begin
    w_pick  = r_ptr;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_ptr) + i) % NUM_CH);
      if (!w_found && bus.ch_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
    end
  end
`endif

  assign w_grant  = (r_state == ST_LOCKED) ? r_lockCh : w_pick;
  assign w_memReq = resetn & bus.ch_req[w_grant] & (w_count < CNT_W'(MAX_OUTSTANDING));
  assign w_hs     = w_memReq & bus.mem_addr_ok;
  assign w_pop    = resetn & bus.mem_data_ok & ~w_empty;

  always_comb begin
    w_addrOk = '0;
    w_dataOk = '0;
    if (w_hs) begin
      w_addrOk[w_grant] = 1'b1;
    end
    if (w_pop) begin
      w_dataOk[w_head] = 1'b1;
    end
  end

  assign bus.mem_req    = w_memReq;
  assign {bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} = w_bundle[w_grant];
  assign bus.ch_addr_ok = w_addrOk;
  assign bus.ch_data_ok = w_dataOk;
  assign bus.ch_rdata   = bus.mem_rdata;

  // Hold the grant on a stalled channel so the downstream request stays stable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_OPEN;
      r_lockCh <= '0;
    end else begin
      case (r_state)
        ST_OPEN: begin
          if (w_memReq && !bus.mem_addr_ok) begin
            r_state  <= ST_LOCKED;
            r_lockCh <= w_grant;
          end
        end
        ST_LOCKED: begin
          if (w_hs || !bus.ch_req[r_lockCh]) begin
            r_state <= ST_OPEN;
          end
        end
        default: r_state <= ST_OPEN;
      endcase
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (CH_W)
  ) u_idFifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_hs & ~w_full),
    .i_din   (w_grant),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
